// File: rtl/freq_meter_pkg.sv
// Shared constants and types for the gated-count frequency meter and its BCD converter.
package freq_meter_pkg;

    localparam int unsigned CLK_HZ         = 50_000_000;
    localparam int unsigned DEF_CNT_W      = 27;
    localparam int unsigned DEF_BCD_DIGITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } bcd_state_e;

endpackage

// File: rtl/freq_meter_bin2bcd_seq.sv
// Sequential shift-add-3 binary to packed BCD converter; one input bit per cycle, MSB first.
module bin2bcd_seq
    import freq_meter_pkg::*;
#(
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned BCD_DIGITS = DEF_BCD_DIGITS
) (
    input  logic                    clk_50mHz,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CNT_W-1:0]        bin,
    output logic [4*BCD_DIGITS-1:0] bcd,
    output logic                    done
);

    localparam int unsigned BW  = 4 * BCD_DIGITS;
    localparam int unsigned SCW = $clog2(CNT_W + 1);

    bcd_state_e     state_q;
    logic [CNT_W-1:0] bin_q;
    logic [BW-1:0]  work_q;
    logic [BW-1:0]  adj;
    logic [SCW-1:0] cnt_q;
    logic           ovf_q;
    logic [BW-1:0]  bcd_q;
    logic           done_q;

    always_comb begin
        adj = work_q;
        for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
            if (work_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // A 1 shifted out of the top digit means the value needs more digits than we have.
    always_ff @(posedge clk_50mHz) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        bin_q   <= bin;
                        work_q  <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    work_q <= {adj[BW-2:0], bin_q[CNT_W-1]};
                    bin_q  <= bin_q << 1;
                    ovf_q  <= ovf_q | adj[BW-1];
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == SCW'(CNT_W - 1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    bcd_q   <= ovf_q ? '1 : work_q;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bcd  = bcd_q;
    assign done = done_q;

endmodule

// File: rtl/freq_meter.sv
// Gated-count frequency meter: counts synchronized rising edges of sig_in over back-to-back
// windows of GATE_CYCLES clocks and reports the count in binary and packed BCD.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = CLK_HZ,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned BCD_DIGITS  = DEF_BCD_DIGITS
) (
    input  logic                    clk_50mHz,
    input  logic                    rst,
    input  logic                    sig_in,
    output logic [CNT_W-1:0]        freq,
    output logic                    freq_valid,
    output logic                    overflow,
    output logic [4*BCD_DIGITS-1:0] freq_bcd,
    output logic                    bcd_valid
);

    localparam int unsigned    GW        = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]  GATE_LAST = GW'(GATE_CYCLES - 1);

    if (GATE_CYCLES < CNT_W + 3) begin : g_gate_too_short
        $error("freq_meter: GATE_CYCLES must be at least CNT_W+3");
    end

    logic             s1_q, s2_q, s3_q;
    logic             edge_det;
    logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0] sum;
    logic             sum_sat, gate_end;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] freq_q, freq_d;
    logic             ovf_q, ovf_d;
    logic             fv_q;

    // The closing gate absorbs an edge seen in its last cycle via the saturating sum.
    always_comb begin
        edge_det   = s2_q & ~s3_q;
        sum_sat    = edge_det & (&edge_cnt_q);
        sum        = (edge_det && !sum_sat) ? edge_cnt_q + 1'b1 : edge_cnt_q;
        gate_end   = (gate_cnt_q == GATE_LAST);
        gate_cnt_d = gate_end ? '0 : gate_cnt_q + 1'b1;
        edge_cnt_d = gate_end ? '0 : sum;
        sat_d      = gate_end ? 1'b0 : (sat_q | sum_sat);
        freq_d     = gate_end ? sum : freq_q;
        ovf_d      = gate_end ? (sat_q | sum_sat) : ovf_q;
    end

    always_ff @(posedge clk_50mHz) begin
        if (rst) begin
            s1_q       <= 1'b1;
            s2_q       <= 1'b1;
            s3_q       <= 1'b1;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            freq_q     <= '0;
            ovf_q      <= 1'b0;
            fv_q       <= 1'b0;
        end else begin
            s1_q       <= sig_in;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
            freq_q     <= freq_d;
            ovf_q      <= ovf_d;
            fv_q       <= gate_end;
        end
    end

    assign freq       = freq_q;
    assign freq_valid = fv_q;
    assign overflow   = ovf_q;

    bin2bcd_seq #(
        .CNT_W      (CNT_W),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_bcd (
        .clk_50mHz (clk_50mHz),
        .rst       (rst),
        .start     (fv_q),
        .bin       (freq_q),
        .bcd       (freq_bcd),
        .done      (bcd_valid)
    );

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: three parameterisations driven from a shared clock/reset/input,
// checked cycle by cycle against an edge-counting reference model of the sampled input.
module tb_freq_meter;

    logic clk_50mHz = 1'b0;
    logic rst       = 1'b1;
    logic sig_in    = 1'b0;

    always #5 clk_50mHz = ~clk_50mHz;

    logic [26:0] freq_a;  logic fv_a, ov_a, bv_a;  logic [31:0] bcd_a;
    logic [3:0]  freq_b;  logic fv_b, ov_b, bv_b;  logic [31:0] bcd_b;
    logic [26:0] freq_c;  logic fv_c, ov_c, bv_c;  logic [7:0]  bcd_c;

    freq_meter #(.GATE_CYCLES(100), .CNT_W(27), .BCD_DIGITS(8)) dut_a (
        .clk_50mHz(clk_50mHz), .rst(rst), .sig_in(sig_in), .freq(freq_a), .freq_valid(fv_a),
        .overflow(ov_a), .freq_bcd(bcd_a), .bcd_valid(bv_a));

    freq_meter #(.GATE_CYCLES(100), .CNT_W(4), .BCD_DIGITS(8)) dut_b (
        .clk_50mHz(clk_50mHz), .rst(rst), .sig_in(sig_in), .freq(freq_b), .freq_valid(fv_b),
        .overflow(ov_b), .freq_bcd(bcd_b), .bcd_valid(bv_b));

    freq_meter #(.GATE_CYCLES(300), .CNT_W(27), .BCD_DIGITS(2)) dut_c (
        .clk_50mHz(clk_50mHz), .rst(rst), .sig_in(sig_in), .freq(freq_c), .freq_valid(fv_c),
        .overflow(ov_c), .freq_bcd(bcd_c), .bcd_valid(bv_c));

    int          sel = 0;
    logic [31:0] m_freq, m_bcd;
    logic        m_fv, m_ov, m_bv;

    always_comb begin
        case (sel)
            1: begin
                m_freq = 32'(freq_b); m_fv = fv_b; m_ov = ov_b; m_bcd = bcd_b; m_bv = bv_b;
            end
            2: begin
                m_freq = 32'(freq_c); m_fv = fv_c; m_ov = ov_c; m_bcd = 32'(bcd_c); m_bv = bv_c;
            end
            default: begin
                m_freq = 32'(freq_a); m_fv = fv_a; m_ov = ov_a; m_bcd = bcd_a; m_bv = bv_a;
            end
        endcase
    end

    int tests = 0;
    int fails = 0;
    bit v [0:4095];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Before reset release the synchronizer holds 1s, so the stream reads high there.
    function automatic bit vs(input int k);
        return (k < 0) ? 1'b1 : v[k];
    endfunction

    // Rising edges of the sampled input, window delayed 2 cycles by the synchronizer.
    function automatic longint gate_edges(input int g, input int gc);
        longint n;
        n = 0;
        for (int j = g * gc - 2; j < (g + 1) * gc - 2; j++) begin
            if (vs(j) && !vs(j - 1)) n++;
        end
        return n;
    endfunction

    function automatic logic [31:0] to_bcd(input longint val, input int d);
        logic [31:0] r;
        longint      lim;
        longint      x;
        r   = '0;
        lim = 1;
        x   = val;
        for (int i = 0; i < d; i++) lim *= 10;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = (val >= lim) ? 4'hF : 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic bit stim(input int mode, input int c);
        case (mode)
            0: return (c % 4) < 2;
            1: return (c == 97) || (c == 99) || (c == 198);
            2: return 1'b1;
            3: return (c < 300) ? (c % 2 == 1) : (((c % 100) < 80) && ((c % 10) == 0));
            4: return (c < 900) ? (c % 3 == 0) : ((c % 3 == 0) && ((c % 300) < 297));
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic run(input int s, input int gc, input int w, input int d, input int mode,
                       input int n);
        int          bv_due;
        logic [31:0] bcd_exp;
        longint      maxv, cnt, fexp;
        bit          fv_exp;
        bv_due  = -1;
        bcd_exp = '0;
        maxv    = (longint'(1) << w) - 1;
        sel     = s;
        rst     = 1'b1;
        sig_in  = (mode == 2);
        @(posedge clk_50mHz); #1;
        @(posedge clk_50mHz); #1;
        check("rst_freq", m_freq, 32'd0);
        check("rst_freq_valid", 32'(m_fv), 32'd0);
        check("rst_overflow", 32'(m_ov), 32'd0);
        check("rst_freq_bcd", m_bcd, 32'd0);
        check("rst_bcd_valid", 32'(m_bv), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < n; c++) begin
            fv_exp = (c > 0) && (c % gc == 0);
            check("freq_valid", 32'(m_fv), 32'(fv_exp));
            if (fv_exp) begin
                cnt  = gate_edges(c / gc - 1, gc);
                fexp = (cnt > maxv) ? maxv : cnt;
                check("freq", m_freq, 32'(fexp));
                check("overflow", 32'(m_ov), 32'(cnt > maxv));
                bcd_exp = to_bcd(fexp, d);
                bv_due  = c + w + 2;
            end
            check("bcd_valid", 32'(m_bv), 32'(c == bv_due));
            if (c == bv_due) check("freq_bcd", m_bcd, bcd_exp);
            v[c]   = stim(mode, c);
            sig_in = v[c];
            @(posedge clk_50mHz); #1;
        end
    endtask

    initial begin
        run(0, 100, 27, 8, 0, 500);   // square wave, period 4
        run(0, 100, 27, 8, 1, 400);   // edges straddling gate boundaries
        run(0, 100, 27, 8, 2, 400);   // static high through reset release
        run(1, 100, 4,  8, 3, 700);   // saturation, then 8 edges per gate
        run(0, 100, 27, 8, 5, 160);   // random; next reset lands at gate cycle 60
        run(0, 100, 27, 8, 5, 450);
        run(1, 100, 4,  8, 5, 300);
        run(2, 300, 27, 2, 4, 1800);  // 100 then 99 edges per gate on 2 digits
        run(2, 300, 27, 2, 5, 700);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
